// File: rtl/mult_div_seq.sv
// Iterative multiply/divide unit feeding the register-file write port (shift-add multiply, restoring divide).
// Optional build macro SIGNED_MULDIV_EN adds the signedOp input for two's-complement operation.
module mult_div_seq #(
  parameter int WIDTH      = 16,
  parameter int REG_ADDR_W = 3,
  parameter int ITER       = WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  op,
`ifdef SIGNED_MULDIV_EN
  input  logic                  signedOp,
`endif
  input  logic [WIDTH-1:0]      srcA,
  input  logic [WIDTH-1:0]      srcB,
  input  logic [REG_ADDR_W-1:0] destReg,
  output logic                  busy,
  output logic                  done,
  output logic                  regWrite,
  output logic [REG_ADDR_W-1:0] writeReg,
  output logic [WIDTH-1:0]      writeData,
  output logic [WIDTH-1:0]      hi,
  output logic                  divByZero
);

  // Handshake: start is accepted only in IDLE (busy low, done low); busy stays high
  // while iterating; done is a one-cycle pulse carrying writeReg/writeData/hi/divByZero.

  localparam int CNT_W = $clog2(ITER + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } stateT;

  stateT state;
  stateT stateNext;

  logic [CNT_W-1:0]      cnt;
  logic                  opR;
  logic                  aNegR;
  logic                  bNegR;
  logic                  dbzR;
  logic [REG_ADDR_W-1:0] destR;
  logic [WIDTH-1:0]      bR;
  logic [WIDTH-1:0]      accHi;
  logic [WIDTH-1:0]      accLo;
  logic [WIDTH-1:0]      resLo;
  logic [WIDTH-1:0]      hiR;

  logic                  isSigned;
  logic                  aNeg;
  logic                  bNeg;
  logic [WIDTH-1:0]      aMag;
  logic [WIDTH-1:0]      bMag;
  logic                  lastStep;
  logic [WIDTH:0]        mulSum;
  logic [WIDTH:0]        divShift;
  logic [WIDTH+1:0]      divTrial;
  logic                  divFits;
  logic [2*WIDTH-1:0]    prod;
  logic [2*WIDTH-1:0]    prodFix;
  logic [WIDTH-1:0]      finalLo;
  logic [WIDTH-1:0]      finalHi;

`ifdef SIGNED_MULDIV_EN
  assign isSigned = signedOp;
`else
  assign isSigned = 1'b0;
`endif

  // Operands are iterated as magnitudes; signs are remembered for the final fixup.
  assign aNeg = isSigned & srcA[WIDTH-1];
  assign bNeg = isSigned & srcB[WIDTH-1];
  assign aMag = aNeg ? ((~srcA) + WIDTH'(1)) : srcA;
  assign bMag = bNeg ? ((~srcB) + WIDTH'(1)) : srcB;

  // cnt runs 0..ITER: ITER iteration edges, then one edge that resolves signs and loads results.
  assign lastStep = (cnt == CNT_W'(ITER));

  assign mulSum   = {1'b0, accHi} + (accLo[0] ? {1'b0, bR} : {(WIDTH+1){1'b0}});
  assign divShift = {accHi, accLo[WIDTH-1]};
  assign divTrial = {1'b0, divShift} - {2'b00, bR};
  assign divFits  = ~divTrial[WIDTH+1];

  assign prod    = {accHi, accLo};
  assign prodFix = (aNegR ^ bNegR) ? ((~prod) + (2*WIDTH)'(1)) : prod;

  // A zero divisor keeps the raw all-ones quotient; only the remainder follows the dividend sign.
  always_comb begin
    finalLo = accLo;
    finalHi = accHi;
    if (!opR) begin
      finalLo = prodFix[WIDTH-1:0];
      finalHi = prodFix[2*WIDTH-1:WIDTH];
    end else begin
      if ((aNegR ^ bNegR) && !dbzR) finalLo = (~accLo) + WIDTH'(1);
      if (aNegR)                    finalHi = (~accHi) + WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    busy      = 1'b0;
    done      = 1'b0;
    regWrite  = 1'b0;
    writeReg  = '0;
    writeData = '0;
    divByZero = 1'b0;
    case (state)
      IDLE: if (start) stateNext = RUN;
      RUN: begin
        busy = 1'b1;
        if (lastStep) stateNext = DONE;
      end
      DONE: begin
        done      = 1'b1;
        regWrite  = (destR != '0);
        writeReg  = destR;
        writeData = resLo;
        divByZero = dbzR;
        stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

  assign hi = hiR;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= '0;
      opR   <= 1'b0;
      aNegR <= 1'b0;
      bNegR <= 1'b0;
      dbzR  <= 1'b0;
      destR <= '0;
      bR    <= '0;
      accHi <= '0;
      accLo <= '0;
      resLo <= '0;
      hiR   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            opR   <= op;
            destR <= destReg;
            aNegR <= aNeg;
            bNegR <= bNeg;
            dbzR  <= op & (srcB == '0);
            bR    <= bMag;
            accHi <= '0;
            accLo <= aMag;
            cnt   <= '0;
          end
        end
        RUN: begin
          if (!lastStep) begin
            cnt <= cnt + CNT_W'(1);
            if (!opR) begin
              {accHi, accLo} <= {mulSum, accLo[WIDTH-1:1]};
            end else begin
              accHi <= divFits ? divTrial[WIDTH-1:0] : divShift[WIDTH-1:0];
              accLo <= {accLo[WIDTH-2:0], divFits};
            end
          end else begin
            resLo <= finalLo;
            hiR   <= finalHi;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_div_seq.sv
// Self-checking bench for mult_div_seq: vector table plus hand-written abort/ignore-start sequences.
// Define SIGNED_MULDIV_EN to include the signed vectors.
module tb_mult_div_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        op = 1'b0;
`ifdef SIGNED_MULDIV_EN
  logic        signedOp = 1'b0;
`endif
  logic [15:0] srcA = '0;
  logic [15:0] srcB = '0;
  logic [2:0]  destReg = '0;
  logic        busy;
  logic        done;
  logic        regWrite;
  logic [2:0]  writeReg;
  logic [15:0] writeData;
  logic [15:0] hi;
  logic        divByZero;

  int checks = 0;
  int errors = 0;
  logic [15:0] exp_q[$];

  typedef struct {
    string       name;
    logic        op;
    logic        sgn;
    logic [15:0] a;
    logic [15:0] b;
    logic [2:0]  dest;
    logic [15:0] expData;
    logic [15:0] expHi;
    logic        expRw;
    logic        expDbz;
  } vecT;

  vecT vecs[$];

  mult_div_seq dut (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
    .op(op),
`ifdef SIGNED_MULDIV_EN
    .signedOp(signedOp),
`endif
    .srcA(srcA),
    .srcB(srcB),
    .destReg(destReg),
    .busy(busy),
    .done(done),
    .regWrite(regWrite),
    .writeReg(writeReg),
    .writeData(writeData),
    .hi(hi),
    .divByZero(divByZero)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, required finish before 200000");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic addVec(input string name, input logic o, input logic s, input logic [15:0] a,
                        input logic [15:0] b, input logic [2:0] d, input logic [15:0] ed,
                        input logic [15:0] eh, input logic rw, input logic dbz);
    vecT v;
    v.name = name; v.op = o; v.sgn = s; v.a = a; v.b = b; v.dest = d;
    v.expData = ed; v.expHi = eh; v.expRw = rw; v.expDbz = dbz;
    vecs.push_back(v);
  endtask

  // Drives one start pulse; returns at the negedge after the start edge.
  task automatic issue(input logic o, input logic s, input logic [15:0] a, input logic [15:0] b,
                       input logic [2:0] d);
    @(negedge clk);
    op = o; srcA = a; srcB = b; destReg = d; start = 1'b1;
`ifdef SIGNED_MULDIV_EN
    signedOp = s;
`else
    if (s) $display("note: signed vector issued in unsigned build");
`endif
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic runVec(input vecT v);
    int lat;
    int busyLow;
    lat = -1;
    busyLow = 0;
    issue(v.op, v.sgn, v.a, v.b, v.dest);
    exp_q.push_back(v.expData);
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (k <= 16 && !busy) busyLow++;
      if (done) begin
        lat = k;
        break;
      end
    end
    chk({v.name, " latency"}, lat, 17);
    chk({v.name, " busy-in-run"}, busyLow, 0);
    if (lat > 0) begin
      chk({v.name, " writeData"}, writeData, exp_q.pop_front());
      chk({v.name, " hi"}, hi, v.expHi);
      chk({v.name, " regWrite"}, regWrite, v.expRw);
      chk({v.name, " writeReg"}, writeReg, v.dest);
      chk({v.name, " divByZero"}, divByZero, v.expDbz);
      chk({v.name, " busy-at-done"}, busy, 0);
      @(negedge clk);
      chk({v.name, " done-after"}, done, 0);
      chk({v.name, " writeData-after"}, writeData, 0);
      chk({v.name, " regWrite-after"}, regWrite, 0);
      chk({v.name, " hi-held"}, hi, v.expHi);
    end else begin
      exp_q.delete();
    end
  endtask

  initial begin
    int firstK;
    int doneCnt;

    addVec("mul7x6",      1'b0, 1'b0, 16'd7,     16'd6,     3'd1, 16'd42,    16'h0000, 1'b1, 1'b0);
    addVec("mulFFFFsq",   1'b0, 1'b0, 16'hFFFF,  16'hFFFF,  3'd3, 16'h0001,  16'hFFFE, 1'b1, 1'b0);
    addVec("div100by7",   1'b1, 1'b0, 16'd100,   16'd7,     3'd2, 16'd14,    16'd2,    1'b1, 1'b0);
    addVec("div50by0",    1'b1, 1'b0, 16'd50,    16'd0,     3'd4, 16'hFFFF,  16'd50,   1'b1, 1'b1);
    addVec("mul5x5r0",    1'b0, 1'b0, 16'd5,     16'd5,     3'd0, 16'd25,    16'h0000, 1'b0, 1'b0);
    addVec("div1234by16", 1'b1, 1'b0, 16'h1234,  16'h0010,  3'd5, 16'h0123,  16'h0004, 1'b1, 1'b0);
    addVec("mul1234x100", 1'b0, 1'b0, 16'h1234,  16'h0100,  3'd7, 16'h3400,  16'h0012, 1'b1, 1'b0);
    addVec("div5by9",     1'b1, 1'b0, 16'd5,     16'd9,     3'd6, 16'd0,     16'd5,    1'b1, 1'b0);
    addVec("divFFFFby1",  1'b1, 1'b0, 16'hFFFF,  16'h0001,  3'd1, 16'hFFFF,  16'h0000, 1'b1, 1'b0);
`ifdef SIGNED_MULDIV_EN
    addVec("smulNeg6x7",  1'b0, 1'b1, 16'hFFFA,  16'd7,     3'd1, 16'hFFD6,  16'hFFFF, 1'b1, 1'b0);
    addVec("sdivNeg7by2", 1'b1, 1'b1, 16'hFFF9,  16'd2,     3'd2, 16'hFFFD,  16'hFFFF, 1'b1, 1'b0);
    addVec("sdivMinByM1", 1'b1, 1'b1, 16'h8000,  16'hFFFF,  3'd3, 16'h8000,  16'h0000, 1'b1, 1'b0);
    addVec("sdiv7byNeg2", 1'b1, 1'b1, 16'd7,     16'hFFFE,  3'd4, 16'hFFFD,  16'h0001, 1'b1, 1'b0);
    addVec("sdivNeg7by0", 1'b1, 1'b1, 16'hFFF9,  16'd0,     3'd5, 16'hFFFF,  16'hFFF9, 1'b1, 1'b1);
`endif

    // reset state
    repeat (3) @(negedge clk);
    chk("reset busy", busy, 0);
    chk("reset done", done, 0);
    chk("reset regWrite", regWrite, 0);
    chk("reset writeData", writeData, 0);
    chk("reset hi", hi, 0);
    rst_n = 1'b1;
    @(negedge clk);

    foreach (vecs[i]) runVec(vecs[i]);

    // start during RUN is ignored and operands are latched
    issue(1'b0, 1'b0, 16'd7, 16'd6, 3'd1);
    exp_q.push_back(16'd42);
    firstK = -1;
    doneCnt = 0;
    for (int k = 1; k <= 45; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (done) begin
        doneCnt++;
        if (firstK < 0) begin
          firstK = k;
          chk("ignore-start writeData", writeData, exp_q.pop_front());
        end
      end
      if (k == 5) begin
        start = 1'b1; srcA = 16'd3; srcB = 16'd3;
      end
      if (k == 6) begin
        start = 1'b0; srcA = 16'd9;
      end
    end
    chk("ignore-start latency", firstK, 17);
    chk("ignore-start done count", doneCnt, 1);
    exp_q.delete();

    // reset mid-operation aborts with no write
    runVec(vecs[2]);
    issue(1'b0, 1'b0, 16'd2, 16'd2, 3'd2);
    repeat (7) begin
      @(posedge clk);
      @(negedge clk);
    end
    chk("pre-abort busy", busy, 1);
    rst_n = 1'b0;
    #1;
    chk("abort busy", busy, 0);
    chk("abort done", done, 0);
    chk("abort regWrite", regWrite, 0);
    chk("abort writeReg", writeReg, 0);
    chk("abort writeData", writeData, 0);
    chk("abort hi", hi, 0);
    chk("abort divByZero", divByZero, 0);
    @(negedge clk);
    rst_n = 1'b1;
    doneCnt = 0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (done) doneCnt++;
    end
    chk("abort no done", doneCnt, 0);
    chk("abort idle busy", busy, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
